// File: rtl/alu_mul_arb.sv
// alu_mul_arb: round-robin arbiter and sequencer that shares one multicycle alu_mul unit
// between NREQ requesters. The winning request's funct and operands are latched, a one-cycle
// strobe is sent to alu_mul, and its done/result is returned to the winner. A watchdog ends a
// stuck operation with an error completion.
//
// Ports:
//   clk          - single clock, rising edge
//   Reset        - synchronous active-high reset
//   req_i        - level request, one bit per requester
//   req_funct_i  - funct per requester, [i*5 +: 5]
//   req_op1_i    - operand 1 per requester, [i*32 +: 32]
//   req_op2_i    - operand 2 per requester, [i*32 +: 32]
//   req_done_o   - one-cycle completion pulse to the granted requester
//   req_err_o    - qualifies req_done_o, 1 = timeout
//   req_res_o    - shared result, valid with req_done_o, held until the next completion
//   busy_o       - high in every state except idle
//   mul_stb_o    - strobe to alu_mul
//   mul_funct_o  - funct to alu_mul
//   mul_op1_o    - operand 1 to alu_mul
//   mul_op2_o    - operand 2 to alu_mul
//   mul_res_i    - result from alu_mul
//   mul_done_i   - done from alu_mul
module alu_mul_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*5-1:0]    req_funct_i,
    input  logic [NREQ*32-1:0]   req_op1_i,
    input  logic [NREQ*32-1:0]   req_op2_i,
    output logic [NREQ-1:0]      req_done_o,
    output logic                 req_err_o,
    output logic [31:0]          req_res_o,
    output logic                 busy_o,
    output logic                 mul_stb_o,
    output logic [4:0]           mul_funct_o,
    output logic [31:0]          mul_op1_o,
    output logic [31:0]          mul_op2_o,
    input  logic [31:0]          mul_res_i,
    input  logic                 mul_done_i
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int          N  = int'(NREQ);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant;
    logic [TW-1:0]   timer;

    logic [GW-1:0]   pick;
    logic            found;

    // Round-robin search starting just above the previous winner, wrapping modulo NREQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_i[(int'(last_grant) + k) % N]) begin
                found = 1'b1;
                pick  = GW'((int'(last_grant) + k) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= StIdle;
            last_grant  <= GW'(NREQ - 1);
            grant       <= '0;
            timer       <= '0;
            req_done_o  <= '0;
            req_err_o   <= 1'b0;
            req_res_o   <= '0;
            busy_o      <= 1'b0;
            mul_stb_o   <= 1'b0;
            mul_funct_o <= '0;
            mul_op1_o   <= '0;
            mul_op2_o   <= '0;
        end else begin
            // Pulse outputs default low; each is raised for one cycle by its state.
            mul_stb_o  <= 1'b0;
            req_done_o <= '0;
            req_err_o  <= 1'b0;

            case (state)
                StIdle: begin
                    if (found) begin
                        grant       <= pick;
                        mul_funct_o <= req_funct_i[pick*5 +: 5];
                        mul_op1_o   <= req_op1_i[pick*32 +: 32];
                        mul_op2_o   <= req_op2_i[pick*32 +: 32];
                        mul_stb_o   <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    timer <= '0;
                    state <= StWait;
                end
                StWait: begin
                    // Done takes priority over a timeout in the same cycle.
                    if (mul_done_i) begin
                        req_res_o  <= mul_res_i;
                        req_err_o  <= 1'b0;
                        req_done_o <= NREQ'(1) << grant;
                        state      <= StResp;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        req_res_o  <= '0;
                        req_err_o  <= 1'b1;
                        req_done_o <= NREQ'(1) << grant;
                        state      <= StResp;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StResp: begin
                    last_grant <= grant;
                    busy_o     <= 1'b0;
                    state      <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_arb.sv
// tb_alu_mul_arb: directed bench for alu_mul_arb with NREQ=2, TIMEOUT=64 and a behavioural
// alu_mul whose done arrives a programmable number of cycles after the strobe.
module tb_alu_mul_arb;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 64;

    logic              clk;
    logic              Reset;
    logic [1:0]        req;
    logic [9:0]        req_funct;
    logic [63:0]       req_op1;
    logic [63:0]       req_op2;
    logic [1:0]        req_done;
    logic              req_err;
    logic [31:0]       req_res;
    logic              busy;
    logic              mul_stb;
    logic [4:0]        mul_funct;
    logic [31:0]       mul_op1;
    logic [31:0]       mul_op2;
    logic [31:0]       mul_res;
    logic              mul_done;

    alu_mul_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .req_i       (req),
        .req_funct_i (req_funct),
        .req_op1_i   (req_op1),
        .req_op2_i   (req_op2),
        .req_done_o  (req_done),
        .req_err_o   (req_err),
        .req_res_o   (req_res),
        .busy_o      (busy),
        .mul_stb_o   (mul_stb),
        .mul_funct_o (mul_funct),
        .mul_op1_o   (mul_op1),
        .mul_op2_o   (mul_op2),
        .mul_res_i   (mul_res),
        .mul_done_i  (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural alu_mul: done lat cycles after the strobe, res = low word of op1*op2.
    logic [31:0] m_op1, m_op2;
    logic        m_pend;
    int          m_cnt;
    int          lat      = 32;
    bit          m_en     = 1'b1;
    bit          inj_done = 1'b0;

    always @(posedge clk) begin
        if (Reset) begin
            m_pend <= 1'b0;
            m_cnt  <= 0;
        end else if (mul_stb) begin
            m_pend <= 1'b1;
            m_cnt  <= 1;
            m_op1  <= mul_op1;
            m_op2  <= mul_op2;
        end else if (m_pend) begin
            if (m_en && m_cnt == lat) m_pend <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end

    assign mul_done = (m_pend && m_en && (m_cnt == lat)) || inj_done;
    assign mul_res  = m_op1 * m_op2;

    // Per-requester vectors and hand-computed products.
    logic [4:0]  t_funct [2] = '{5'b01110, 5'b01111};
    logic [31:0] t_op1   [2] = '{32'hFFFFF8E1, 32'hFFFFFED7};
    logic [31:0] t_op2   [2] = '{32'd10, 32'd16};
    logic [31:0] t_res   [2] = '{32'hFFFFB8CA, 32'hFFFFED70};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
        check_eq({tag, "_stb"},   32'(mul_stb),   32'd0);
        check_eq({tag, "_done"},  32'(req_done),  32'd0);
        check_eq({tag, "_err"},   32'(req_err),   32'd0);
        check_eq({tag, "_res"},   req_res,        32'd0);
        check_eq({tag, "_funct"}, 32'(mul_funct), 32'd0);
        check_eq({tag, "_op1"},   mul_op1,        32'd0);
        check_eq({tag, "_op2"},   mul_op2,        32'd0);
    endtask

    // Entered in an idle cycle with req already driven; returns in the completion cycle.
    task automatic run_op(input string tag, input int g, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_res, output int stb_cyc);
        int n;
        int busy_bad;
        tick();
        stb_cyc = cyc;
        check_eq({tag, "_stb"},   32'(mul_stb),   32'd1);
        check_eq({tag, "_funct"}, 32'(mul_funct), 32'(t_funct[g]));
        check_eq({tag, "_op1"},   mul_op1,        t_op1[g]);
        check_eq({tag, "_op2"},   mul_op2,        t_op2[g]);
        check_eq({tag, "_busy"},  32'(busy),      32'd1);
        tick();
        check_eq({tag, "_stb_1cyc"}, 32'(mul_stb), 32'd0);
        n        = 0;
        busy_bad = 0;
        while (req_done == 2'b00 && n < 200) begin
            if (!busy) busy_bad++;
            tick();
            n++;
        end
        check_eq({tag, "_latency"},  32'(n),        32'(exp_lat));
        check_eq({tag, "_done_vec"}, 32'(req_done), 32'(2'b01 << g));
        check_eq({tag, "_err"},      32'(req_err),  32'(exp_err));
        check_eq({tag, "_res"},      req_res,       exp_res);
        check_eq({tag, "_busy_hi"},  32'(busy_bad), 32'd0);
    endtask

    initial begin
        int s, prev_s, bad;
        Reset     = 1'b1;
        req       = 2'b00;
        req_funct = {t_funct[1], t_funct[0]};
        req_op1   = {t_op1[1], t_op1[0]};
        req_op2   = {t_op2[1], t_op2[0]};
        tick();
        tick();
        Reset = 1'b0;
        check_reset_vals("rst");

        // Single request from requester 0.
        req = 2'b01;
        run_op("single", 0, 32, 1'b0, t_res[0], s);
        req = 2'b00;
        tick();
        check_eq("single_done_clr", 32'(req_done), 32'd0);
        check_eq("single_busy_lo",  32'(busy),     32'd0);
        check_eq("single_res_hold", req_res,       t_res[0]);

        // Simultaneous pair after requester 0 was last served: 1 first, then 0.
        req = 2'b11;
        run_op("pairA1", 1, 32, 1'b0, t_res[1], s);
        req = 2'b01;
        tick();
        run_op("pairA0", 0, 32, 1'b0, t_res[0], s);
        req = 2'b00;

        // Simultaneous pair straight after reset: 0 first, then 1.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req   = 2'b11;
        run_op("pairB0", 0, 32, 1'b0, t_res[0], s);
        req = 2'b10;
        tick();
        run_op("pairB1", 1, 32, 1'b0, t_res[1], s);

        // Both held high: strict alternation, strobes spaced by latency + 3.
        req = 2'b11;
        tick();
        prev_s = 0;
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("rr%0d", i), i % 2, 32, 1'b0, t_res[i % 2], s);
            if (i > 0) check_eq($sformatf("rr%0d_spacing", i), 32'(s - prev_s), 32'd35);
            prev_s = s;
            tick();
        end

        // Now idle again after the 6th op (req still 11 sampled here would start op 7).
        req = 2'b00;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        // last_grant back to 1 so requester 1's slot is last; use a single req for the timeout.

        // Model never answers: error completion TIMEOUT cycles into WAIT.
        m_en = 1'b0;
        req  = 2'b01;
        run_op("timeout", 0, int'(TIMEOUT), 1'b1, 32'd0, s);
        m_en = 1'b1;
        req  = 2'b10;
        tick();
        run_op("after_to", 1, 32, 1'b0, t_res[1], s);

        // Done in the last cycle before the watchdog fires: done wins.
        lat = int'(TIMEOUT);
        req = 2'b01;
        tick();
        run_op("late_done", 0, int'(TIMEOUT), 1'b0, t_res[0], s);
        lat = 32;

        // Reset mid-WAIT: no completion, later done ignored, requester 0 regains priority.
        req = 2'b01;
        tick();
        tick();
        check_eq("midrst_stb", 32'(mul_stb), 32'd1);
        repeat (10) tick();
        Reset = 1'b1;
        req   = 2'b00;
        tick();
        Reset = 1'b0;
        check_reset_vals("midrst");
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_done != 2'b00 || busy) bad++;
            tick();
        end
        check_eq("midrst_quiet", 32'(bad), 32'd0);
        req = 2'b11;
        run_op("midrst_next", 0, 32, 1'b0, t_res[0], s);
        req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
